// File: rtl/dcache_bus_defs.sv
// Shared cache-bus / AXI4 constants and bridge FSM state encodings.
package dcache_bus_defs;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned LINE_BEATS    = 2;
    localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);
    localparam logic [7:0] AXI_WSTRB_ALL  = 8'hff;

    localparam logic [2:0] W_IDLE = 3'd0;
    localparam logic [2:0] W_B0   = 3'd1;
    localparam logic [2:0] W_GAP  = 3'd2;
    localparam logic [2:0] W_B1   = 3'd3;
    localparam logic [2:0] W_AXI  = 3'd4;
    localparam logic [2:0] W_RESP = 3'd5;
    localparam logic [2:0] W_DONE = 3'd6;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_DONE = 2'd3;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// DCache refill/eviction to AXI4 bridge: each cache line moves as one 2-beat INCR burst.
// Independent read and write FSMs so a refill can overlap a dirty eviction.
module dcache_axi_bridge
    import dcache_bus_defs::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cb_w_valid,
    output logic                  cb_w_ready,
    input  logic [63:0]           cb_w_waddr,
    input  logic [63:0]           cb_w_wdata,
    input  logic                  cb_w_wlast,
    input  logic                  cb_b_ready,
    output logic                  cb_b_valid,

    input  logic                  cb_r_valid,
    input  logic [63:0]           cb_r_raddr,
    output logic                  cb_r_ready,
    output logic [63:0]           cb_r_rdata,
    output logic                  cb_r_rlast,

    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_ADDR_W-1:0] m_awaddr,
    output logic [AXI_ID_W-1:0]   m_awid,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [63:0]           m_wdata,
    output logic [7:0]            m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    input  logic [AXI_ID_W-1:0]   m_bid,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [AXI_ID_W-1:0]   m_arid,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [63:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [AXI_ID_W-1:0]   m_rid,

    output logic                  bus_err
);

    localparam logic [AXI_ID_W-1:0] ID_VAL = AXI_ID_W'(AXI_ID);

    logic [2:0]            w_state;
    logic [AXI_ADDR_W-1:0] w_addr;
    logic [63:0]           w_beat0;
    logic [63:0]           w_beat1;
    logic                  aw_done;
    logic                  w_sel;
    logic                  w_done;
    logic                  w_err;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  w_take_b1;

    logic [1:0]            r_state;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic                  r_err;
    logic                  r_beat;

    logic                  unused_inputs;

    assign aw_fire   = m_awvalid & m_awready;
    assign w_fire    = m_wvalid & m_wready;
    assign w_take_b1 = (w_state == W_B1) & cb_w_valid & cb_w_wlast;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_beat0 <= '0;
            w_beat1 <= '0;
            aw_done <= 1'b0;
            w_sel   <= 1'b0;
            w_done  <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (cb_w_valid && !cb_w_wlast) begin
                    w_addr  <= cb_w_waddr[AXI_ADDR_W-1:0];
                    w_beat0 <= cb_w_wdata;
                    w_state <= W_B0;
                end
                W_B0:  w_state <= W_GAP;
                W_GAP: w_state <= W_B1;
                W_B1: if (w_take_b1) begin
                    w_beat1 <= cb_w_wdata;
                    w_state <= W_AXI;
                end
                W_AXI: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire) begin
                        if (w_sel) w_done <= 1'b1;
                        else       w_sel  <= 1'b1;
                    end
                    // AW and W complete independently; leave once both have
                    if ((aw_done || aw_fire) && (w_done || (w_fire && w_sel))) begin
                        aw_done <= 1'b0;
                        w_sel   <= 1'b0;
                        w_done  <= 1'b0;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (m_bvalid) begin
                    if (resp_is_err(m_bresp)) w_err <= 1'b1;
                    w_state <= W_DONE;
                end
                W_DONE: if (cb_b_ready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign r_beat = (r_state == R_DATA) & m_rvalid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (cb_r_valid) begin
                    r_addr  <= cb_r_raddr[AXI_ADDR_W-1:0];
                    r_state <= R_AR;
                end
                R_AR: if (m_arready) r_state <= R_DATA;
                R_DATA: if (m_rvalid) begin
                    if (resp_is_err(m_rresp)) r_err <= 1'b1;
                    if (m_rlast) r_state <= R_DONE;
                end
                // cache still holds the request one cycle past rlast; wait it out
                R_DONE: if (!cb_r_valid) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign cb_w_ready = (w_state == W_B0) | w_take_b1;
    assign cb_b_valid = (w_state == W_DONE) & cb_b_ready;

    // Burst attributes are gated by valid so every output reads 0 in reset
    assign m_awvalid = (w_state == W_AXI) & ~aw_done;
    assign m_awaddr  = w_addr;
    assign m_awid    = m_awvalid ? ID_VAL : '0;
    assign m_awlen   = m_awvalid ? AXI_LEN_LINE : '0;
    assign m_awsize  = m_awvalid ? AXI_SIZE_8B : '0;
    assign m_awburst = m_awvalid ? AXI_BURST_INCR : '0;
    assign m_wvalid  = (w_state == W_AXI) & ~w_done;
    assign m_wdata   = w_sel ? w_beat1 : w_beat0;
    assign m_wstrb   = m_wvalid ? AXI_WSTRB_ALL : '0;
    assign m_wlast   = m_wvalid & w_sel;
    assign m_bready  = (w_state == W_RESP);

    assign m_arvalid = (r_state == R_AR);
    assign m_araddr  = r_addr;
    assign m_arid    = m_arvalid ? ID_VAL : '0;
    assign m_arlen   = m_arvalid ? AXI_LEN_LINE : '0;
    assign m_arsize  = m_arvalid ? AXI_SIZE_8B : '0;
    assign m_arburst = m_arvalid ? AXI_BURST_INCR : '0;
    assign m_rready  = (r_state == R_DATA);

    assign cb_r_ready = r_beat;
    assign cb_r_rdata = r_beat ? m_rdata : '0;
    assign cb_r_rlast = r_beat & m_rlast;

    assign bus_err = w_err | r_err;

    assign unused_inputs = ^{cb_w_waddr[63:AXI_ADDR_W], cb_r_raddr[63:AXI_ADDR_W], m_bid, m_rid};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Scoreboard bench for dcache_axi_bridge: directed cache-side transfers against a configurable AXI slave.
`timescale 1ns/1ps
module tb_dcache_axi_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cb_w_valid, cb_w_ready, cb_w_wlast, cb_b_ready, cb_b_valid;
    logic [63:0] cb_w_waddr, cb_w_wdata;
    logic        cb_r_valid, cb_r_ready, cb_r_rlast;
    logic [63:0] cb_r_raddr, cb_r_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_araddr;
    logic [3:0]  m_awid, m_bid, m_arid, m_rid;
    logic [7:0]  m_awlen, m_arlen, m_wstrb;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
    logic [63:0] m_wdata, m_rdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic        bus_err;

    dcache_axi_bridge #(.AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_ID(0)) dut (
        .clock(clock), .reset(reset),
        .cb_w_valid(cb_w_valid), .cb_w_ready(cb_w_ready), .cb_w_waddr(cb_w_waddr),
        .cb_w_wdata(cb_w_wdata), .cb_w_wlast(cb_w_wlast), .cb_b_ready(cb_b_ready),
        .cb_b_valid(cb_b_valid), .cb_r_valid(cb_r_valid), .cb_r_raddr(cb_r_raddr),
        .cb_r_ready(cb_r_ready), .cb_r_rdata(cb_r_rdata), .cb_r_rlast(cb_r_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_bid(m_bid), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [64:0] exp_w[$];
    logic [64:0] exp_r[$];
    int          exp_b = 0;
    int          r_done_cycle = 0;
    int          b_done_cycle = 0;

    int          aw_delay = 0, w_stall = 0, ar_delay = 0, r_gap = 0, r_err_beat = -1;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [63:0] r_data_cfg[2];
    int          r_left = 0, r_idx = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, why);
    endtask

    initial forever begin
        @(posedge clock);
        cycle++;
    end

    initial begin : aw_slave
        int cnt;
        cnt = 0;
        m_awready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset || m_awready) begin
                cnt = 0;
                m_awready = 1'b0;
            end else if (m_awvalid) begin
                if (cnt >= aw_delay) m_awready = 1'b1;
                else cnt++;
            end
        end
    end

    initial begin : w_slave
        int cnt;
        cnt = 0;
        m_wready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset || m_wready) begin
                cnt = 0;
                m_wready = 1'b0;
            end else if (m_wvalid) begin
                if (cnt >= w_stall) m_wready = 1'b1;
                else cnt++;
            end
        end
    end

    initial begin : b_slave
        m_bvalid = 1'b0;
        m_bresp = 2'b00;
        m_bid = '0;
        forever begin
            @(posedge clock); #1;
            if (!reset || m_bvalid) m_bvalid = 1'b0;
            else if (m_bready) begin
                m_bvalid = 1'b1;
                m_bresp = b_resp_cfg;
            end
        end
    end

    initial begin : ar_r_slave
        int cnt, gap;
        cnt = 0;
        gap = 0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_rlast = 1'b0;
        m_rresp = 2'b00;
        m_rid = '0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                cnt = 0; gap = 0; r_left = 0;
                m_arready = 1'b0;
                m_rvalid = 1'b0;
            end else begin
                if (m_arready) begin
                    m_arready = 1'b0;
                    cnt = 0; gap = 0; r_left = 2; r_idx = 0;
                end else if (m_arvalid) begin
                    if (cnt >= ar_delay) m_arready = 1'b1;
                    else cnt++;
                end
                if (m_rvalid) begin
                    m_rvalid = 1'b0;
                    r_left--;
                    r_idx++;
                    gap = 0;
                end
                if (!m_rvalid && r_left > 0) begin
                    if (gap >= r_gap) begin
                        m_rvalid = 1'b1;
                        m_rdata = r_data_cfg[r_idx];
                        m_rlast = (r_left == 1);
                        m_rresp = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
                    end else gap++;
                end
            end
        end
    end

    initial begin : monitor
        logic aw_pend, w_pend, ar_pend;
        logic [31:0] aw_hold, ar_hold;
        logic [64:0] w_hold;
        int b_hs_cycle;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_hold = '0; ar_hold = '0; w_hold = '0;
        b_hs_cycle = -10;
        forever begin
            @(negedge clock);
            if (!reset) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend) check("aw_stable", {m_awvalid, m_awaddr}, {1'b1, aw_hold});
                if (w_pend)  check("w_stable", {m_wvalid, m_wlast, m_wdata}, {1'b1, w_hold});
                if (ar_pend) check("ar_stable", {m_arvalid, m_araddr}, {1'b1, ar_hold});
                aw_pend = m_awvalid & ~m_awready;  aw_hold = m_awaddr;
                w_pend  = m_wvalid & ~m_wready;    w_hold  = {m_wlast, m_wdata};
                ar_pend = m_arvalid & ~m_arready;  ar_hold = m_araddr;

                if (m_awvalid && m_awready) begin
                    if (exp_aw.size() == 0) fail_now("aw_extra", "unexpected AW handshake");
                    else check("aw_addr", m_awaddr, exp_aw.pop_front());
                    check("aw_attr", {m_awlen, m_awsize, m_awburst, m_awid}, {8'd1, 3'd3, 2'b01, 4'd0});
                end
                if (m_wvalid && m_wready) begin
                    if (exp_w.size() == 0) fail_now("w_extra", "unexpected W beat");
                    else check("w_beat", {m_wlast, m_wdata}, exp_w.pop_front());
                    check("w_strb", m_wstrb, 8'hff);
                end
                if (m_arvalid && m_arready) begin
                    if (exp_ar.size() == 0) fail_now("ar_extra", "unexpected AR handshake");
                    else check("ar_addr", m_araddr, exp_ar.pop_front());
                    check("ar_attr", {m_arlen, m_arsize, m_arburst, m_arid}, {8'd1, 3'd3, 2'b01, 4'd0});
                end
                if (cb_r_ready) begin
                    if (exp_r.size() == 0) fail_now("r_extra", "unexpected cb_r_ready");
                    else check("r_beat", {cb_r_rlast, cb_r_rdata}, exp_r.pop_front());
                end
                if (cb_r_rlast) r_done_cycle = cycle;
                if (m_bvalid && m_bready) b_hs_cycle = cycle;
                if (cb_b_valid) begin
                    if (exp_b == 0) fail_now("b_extra", "unexpected cb_b_valid");
                    else begin
                        exp_b--;
                        check("b_latency", 32'(cycle), 32'(b_hs_cycle + 1));
                    end
                    b_done_cycle = cycle;
                end
            end
        end
    end

    task automatic wait_w_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cb_w_ready && n < 60);
        if (!cb_w_ready) fail_now(name, "cb_w_ready timeout");
    endtask

    task automatic evict(input logic [63:0] addr, input logic [63:0] a, input logic [63:0] b);
        @(posedge clock); #1;
        exp_aw.push_back(addr[31:0]);
        exp_w.push_back({1'b0, a});
        exp_w.push_back({1'b1, b});
        exp_b++;
        cb_w_valid = 1'b1; cb_w_waddr = addr; cb_w_wdata = a; cb_w_wlast = 1'b0;
        wait_w_ready("w_ready0");
        @(posedge clock); #1;
        cb_w_wdata = b; cb_w_wlast = 1'b1;
        @(negedge clock);
        check("w_gap", cb_w_ready, 1'b0);
        wait_w_ready("w_ready1");
        @(posedge clock); #1;
        cb_w_valid = 1'b0; cb_w_wlast = 1'b0;
    endtask

    task automatic refill(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1);
        int n;
        @(posedge clock); #1;
        exp_ar.push_back(addr[31:0]);
        exp_r.push_back({1'b0, d0});
        exp_r.push_back({1'b1, d1});
        r_data_cfg[0] = d0;
        r_data_cfg[1] = d1;
        cb_r_valid = 1'b1; cb_r_raddr = addr;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cb_r_rlast && n < 100);
        if (!cb_r_rlast) fail_now("r_rlast", "refill timeout");
        @(posedge clock); #1;
        cb_r_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size() + exp_b) != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) fail_now(name, "outstanding transfers never completed");
        repeat (3) @(negedge clock);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready,
                               cb_w_ready, cb_b_valid, cb_r_ready, cb_r_rlast, bus_err}, '0);
        check({name, "_data"}, {m_awaddr, m_araddr, m_wdata, cb_r_rdata}, '0);
        check({name, "_attr"}, {m_awlen, m_awsize, m_awburst, m_awid, m_arlen, m_arsize,
                                m_arburst, m_arid, m_wstrb}, '0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        cb_w_valid = 0; cb_w_waddr = '0; cb_w_wdata = '0; cb_w_wlast = 0;
        cb_b_ready = 1; cb_r_valid = 0; cb_r_raddr = '0;
        reset = 0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clock);
        #1 reset = 1;

        refill(64'h0000_0000_8000_0040, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        wait_idle("refill_only");

        evict(64'h0000_0000_8000_1000, 64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002);
        wait_idle("evict_only");

        aw_delay = 5;
        fork
            evict(64'h0000_0000_8000_2000, 64'hCCCC_CCCC_0000_0003, 64'hDDDD_DDDD_0000_0004);
            refill(64'h0000_0000_8000_0080, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        join
        wait_idle("concurrent");
        check("read_first", r_done_cycle < b_done_cycle, 1'b1);
        aw_delay = 0;

        w_stall = 3; r_gap = 2;
        fork
            evict(64'h0000_0000_8000_3000, 64'hEEEE_0101_EEEE_0101, 64'hFFFF_0202_FFFF_0202);
            refill(64'hFFFF_0000_8000_00C0, 64'h5555_AAAA_5555_AAAA, 64'h6666_BBBB_6666_BBBB);
        join
        wait_idle("backpressure");
        w_stall = 0; r_gap = 0;
        check("bus_err_clean", bus_err, 1'b0);

        r_err_beat = 1;
        refill(64'h0000_0000_8000_0100, 64'h7777_0000_7777_0000, 64'h8888_0000_8888_0000);
        wait_idle("rresp_err");
        r_err_beat = -1;
        check("bus_err_set", bus_err, 1'b1);
        evict(64'h0000_0000_8000_1100, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        wait_idle("after_err");
        check("bus_err_sticky", bus_err, 1'b1);

        aw_delay = 30; w_stall = 30;
        evict(64'h0000_0000_8000_5000, 64'h9999_0000_0000_9999, 64'h1234_0000_0000_4321);
        @(posedge clock); #1;
        check("mid_axi", m_awvalid, 1'b1);
        reset = 0;
        #1;
        check_all_zero("mid_reset");
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_r.delete(); exp_b = 0;
        aw_delay = 0; w_stall = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
        evict(64'h0000_0000_8000_4000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
        wait_idle("post_reset_evict");
        check("bus_err_post_reset", bus_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
